// File: rtl/led_fade_sequencer.sv
// Steps per-channel PWM compare values through up/hold/down brightness ramps,
// either all channels together (breathe) or one channel per fade (chase).
module led_fade_sequencer #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CTR_LEN     = 8,
  parameter int unsigned DIV_W       = 20,
  parameter int unsigned DEFAULT_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [7:0]                cfg_hold,
  input  logic                      cfg_mode,
  output logic [NUM_CH*CTR_LEN-1:0] compare,
  output logic                      busy,
  output logic                      cycle_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;

  localparam int unsigned        PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_CH - 1);
  localparam logic [CTR_LEN-1:0] LVL_MAX  = '1;
  localparam logic [CTR_LEN-1:0] LVL_TOP  = LVL_MAX - CTR_LEN'(1);
  localparam logic [CTR_LEN-1:0] LVL_ONE  = CTR_LEN'(1);

  logic [1:0]         state;
  logic [CTR_LEN-1:0] level;
  logic [PTR_W-1:0]   ptr;
  logic [7:0]         hold_cnt;
  logic [DIV_W-1:0]   prescaler;
  logic [DIV_W-1:0]   div;
  logic [7:0]         hold;
  logic               mode;
  logic [DIV_W-1:0]   div_last;
  logic               tick;

  // div of 0 behaves exactly like div of 1: a tick every cycle.
  assign div_last  = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick      = (state != ST_IDLE) && (prescaler == div_last);
  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      level      <= '0;
      ptr        <= '0;
      hold_cnt   <= '0;
      prescaler  <= '0;
      div        <= DIV_W'(DEFAULT_DIV);
      hold       <= '0;
      mode       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (cfg_valid && cfg_ready) begin
        div  <= cfg_div;
        hold <= cfg_hold;
        mode <= cfg_mode;
      end
      if (state == ST_IDLE) begin
        if (enable) begin
          state     <= ST_UP;
          level     <= '0;
          prescaler <= '0;
          hold_cnt  <= '0;
        end
      end else begin
        prescaler <= tick ? '0 : prescaler + DIV_W'(1);
        if (tick) begin
          case (state)
            ST_UP: begin
              if (level != LVL_MAX) level <= level + LVL_ONE;
              if (level >= LVL_TOP) state <= ST_HOLD;
            end
            ST_HOLD: begin
              if (hold_cnt == hold) begin
                state    <= ST_DOWN;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
            ST_DOWN: begin
              if (level != '0) level <= level - LVL_ONE;
              if (level <= LVL_ONE) begin
                cycle_done <= 1'b1;
                hold_cnt   <= '0;
                if (mode) ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
                state <= enable ? ST_UP : ST_IDLE;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    compare = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!mode || (ptr == PTR_W'(i)))
        compare[i*CTR_LEN +: CTR_LEN] = level;
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with 8 channels of 3-bit levels (MAX = 7).
module tb_led_fade_sequencer;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned CTR_LEN = 3;
  localparam int unsigned DIV_W   = 20;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      enable;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [DIV_W-1:0]          cfg_div;
  logic [7:0]                cfg_hold;
  logic                      cfg_mode;
  logic [NUM_CH*CTR_LEN-1:0] compare;
  logic                      busy;
  logic                      cycle_done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  led_fade_sequencer #(
    .NUM_CH(NUM_CH), .CTR_LEN(CTR_LEN), .DIV_W(DIV_W), .DEFAULT_DIV(50000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div),
    .cfg_hold(cfg_hold), .cfg_mode(cfg_mode), .compare(compare),
    .busy(busy), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Level after n ticks of a fade with the given hold setting (MAX = 7).
  function automatic int exp_level(input int n, input int hd);
    if (n <= 0) return 0;
    if (n <= 7) return n;
    if (n <= 8 + hd) return 7;
    if (15 + hd - n < 0) return 0;
    return 15 + hd - n;
  endfunction

  function automatic logic [NUM_CH*CTR_LEN-1:0] exp_cmp(input int lvl, input bit md, input int ch);
    logic [NUM_CH*CTR_LEN-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (!md || i == ch) e[i*CTR_LEN +: CTR_LEN] = CTR_LEN'(lvl);
    return e;
  endfunction

  // Checks clocks k0..k1 of a fade that entered UP at clock 0.
  task automatic check_ticks(input int dv, input int hd, input bit md, input int ch,
                             input int k0, input int k1);
    int end_k;
    end_k = dv * (15 + hd);
    for (int k = k0; k <= k1; k++) begin
      step();
      check_eq($sformatf("compare k=%0d", k), 32'(compare),
               32'(exp_cmp(exp_level(k / dv, hd), md, ch)));
      check_eq($sformatf("cycle_done k=%0d", k), 32'(cycle_done), 32'(k == end_k));
      check_eq($sformatf("busy k=%0d", k), 32'(busy), (k == end_k) ? 32'(enable) : 32'd1);
      if (cycle_done) done_cnt++;
    end
  endtask

  task automatic start_cfg(input int dv, input int hd, input bit md);
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(dv);
    cfg_hold  = 8'(hd);
    cfg_mode  = md;
    enable    = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_div = '0; cfg_hold = '0; cfg_mode = 1'b0;
    step(); step();
    check_eq("rst compare", 32'(compare), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst cycle_done", 32'(cycle_done), 32'd0);
    rst_n = 1'b1;
    step();

    // Breathe, div=1 hold=0, config and enable in the same IDLE cycle
    start_cfg(1, 0, 1'b0);
    check_eq("entry busy", 32'(busy), 32'd1);
    check_eq("entry cfg_ready", 32'(cfg_ready), 32'd0);
    check_eq("entry compare", 32'(compare), 32'd0);
    check_ticks(1, 0, 1'b0, 0, 1, 15);

    // Second fade: config while busy is ignored, enable dropped at level 5
    cfg_valid = 1'b1; cfg_div = 20'd4; cfg_hold = 8'd5; cfg_mode = 1'b1;
    check_ticks(1, 0, 1'b0, 0, 1, 5);
    check_eq("busy cfg_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    enable = 1'b0;
    check_ticks(1, 0, 1'b0, 0, 6, 15);
    step();
    check_eq("idle busy", 32'(busy), 32'd0);
    check_eq("idle cycle_done", 32'(cycle_done), 32'd0);
    check_eq("idle cfg_ready", 32'(cfg_ready), 32'd1);

    // Old config retained: breathe, div=1, hold=0
    enable = 1'b1;
    step();
    enable = 1'b0;
    check_ticks(1, 0, 1'b0, 0, 1, 15);
    check_eq("kept cfg busy", 32'(busy), 32'd0);

    // Chase over nine fades; pointer wraps back to ch0
    start_cfg(1, 0, 1'b1);
    done_cnt = 0;
    for (int f = 0; f < 9; f++) begin
      if (f == 8) begin
        check_eq("chase done count", 32'(done_cnt), 32'd8);
        enable = 1'b0;
      end
      check_ticks(1, 0, 1'b1, f % 8, 1, 15);
    end
    check_eq("chase end busy", 32'(busy), 32'd0);

    // div=4 hold=2: step every 4 clks, MAX held through 3 hold ticks
    start_cfg(4, 2, 1'b0);
    enable = 1'b0;
    check_ticks(4, 2, 1'b0, 0, 1, 68);
    check_eq("div4 end busy", 32'(busy), 32'd0);

    // div=0 behaves like div=1
    start_cfg(0, 0, 1'b0);
    enable = 1'b0;
    check_ticks(1, 0, 1'b0, 0, 1, 15);
    check_eq("div0 end busy", 32'(busy), 32'd0);

    // Reset asserted mid-HOLD aborts without a completion pulse
    start_cfg(1, 3, 1'b0);
    enable = 1'b0;
    check_ticks(1, 3, 1'b0, 0, 1, 9);
    rst_n = 1'b0;
    #1;
    check_eq("async rst compare", 32'(compare), 32'd0);
    check_eq("async rst busy", 32'(busy), 32'd0);
    check_eq("async rst cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("async rst cycle_done", 32'(cycle_done), 32'd0);
    step();
    check_eq("rst hold cycle_done", 32'(cycle_done), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("post rst busy", 32'(busy), 32'd0);
    check_eq("post rst cycle_done", 32'(cycle_done), 32'd0);
    check_eq("post rst compare", 32'(compare), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
